// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one instruction-memory port between CPU fetches
// (reads) and the program loader (writes, staged through a small FIFO).
// Fetches win the port unless the write buffer is full, the fetch address
// matches a buffered write, or fetches have starved the buffer too long.
// Optional macro IMEM_ARB_STATS_EN adds a 16-bit saturating counter of
// cycles in which a fetch request was refused (stat_fetch_stalls).
module imem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int WBUF_DEPTH = 4,
    parameter int MAX_STALL  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address_out,
    output logic [ADDR_W-1:0] mem_address_in,
    output logic [DATA_W-1:0] mem_instruction_in,
    output logic              mem_write,
`ifdef IMEM_ARB_STATS_EN
    output logic [15:0]       stat_fetch_stalls,
`endif
    input  logic [DATA_W-1:0] mem_instruction_out
);

    localparam int PTR_W   = $clog2(WBUF_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int STALL_W = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0]   DEPTH_C     = CNT_W'(WBUF_DEPTH);
    localparam logic [STALL_W-1:0] STALL_MAX_C = STALL_W'(MAX_STALL);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

    // Write-buffer storage (data only, no reset needed)
    logic [ADDR_W-1:0] buf_addr [WBUF_DEPTH];
    logic [DATA_W-1:0] buf_data [WBUF_DEPTH];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic [ADDR_W-1:0] mem_address_out_q, mem_address_out_d;
    logic [ADDR_W-1:0] mem_address_in_q, mem_address_in_d;
    logic [DATA_W-1:0] mem_instruction_in_q, mem_instruction_in_d;
    logic              mem_write_q, mem_write_d;

    logic full, empty, hazard, gnt, push, pop;
    logic [PTR_W-1:0] offset;

    // Read-after-write hazard: fetch address matches any occupied buffer slot
    always_comb begin
        hazard = 1'b0;
        offset = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) && (buf_addr[i] == fetch_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    // Arbitration, buffer bookkeeping and next values of all registered outputs
    always_comb begin
        full  = (count_q == DEPTH_C);
        empty = (count_q == '0);
        gnt   = 1'b0;

        // Priority order: full, hazard, starvation, fetch, drain, idle
        if (full) begin
            state_d = ST_WRITE;
        end else if (fetch_req && hazard) begin
            state_d = ST_WRITE;
        end else if ((stall_q >= STALL_MAX_C) && !empty) begin
            state_d = ST_WRITE;
        end else if (fetch_req) begin
            state_d = ST_READ;
            gnt     = 1'b1;
        end else if (!empty) begin
            state_d = ST_WRITE;
        end else begin
            state_d = ST_IDLE;
        end

        push = wr_valid && !full;
        pop  = (state_d == ST_WRITE);

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // Starvation counter only runs while reads keep a non-empty buffer waiting
        stall_d = stall_q;
        if (pop || empty) begin
            stall_d = '0;
        end else if ((state_d == ST_READ) && (stall_q != STALL_MAX_C)) begin
            stall_d = stall_q + STALL_W'(1);
        end

        mem_write_d          = pop;
        mem_address_in_d     = pop ? buf_addr[rd_ptr_q] : mem_address_in_q;
        mem_instruction_in_d = pop ? buf_data[rd_ptr_q] : mem_instruction_in_q;
        mem_address_out_d    = (state_d == ST_READ) ? fetch_addr : mem_address_out_q;

        // Memory returned data on the falling edge of the READ cycle
        fetch_valid_d = (state_q == ST_READ);
        fetch_data_d  = (state_q == ST_READ) ? mem_instruction_out : fetch_data_q;
    end

    // Port state machine and registered memory/fetch outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= ST_IDLE;
            count_q              <= '0;
            wr_ptr_q             <= '0;
            rd_ptr_q             <= '0;
            stall_q              <= '0;
            fetch_valid_q        <= 1'b0;
            fetch_data_q         <= '0;
            mem_address_out_q    <= '0;
            mem_address_in_q     <= '0;
            mem_instruction_in_q <= '0;
            mem_write_q          <= 1'b0;
        end else begin
            state_q              <= state_d;
            count_q              <= count_d;
            wr_ptr_q             <= wr_ptr_d;
            rd_ptr_q             <= rd_ptr_d;
            stall_q              <= stall_d;
            fetch_valid_q        <= fetch_valid_d;
            fetch_data_q         <= fetch_data_d;
            mem_address_out_q    <= mem_address_out_d;
            mem_address_in_q     <= mem_address_in_d;
            mem_instruction_in_q <= mem_instruction_in_d;
            mem_write_q          <= mem_write_d;
        end
    end

    // Capture loader writes into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr_q] <= wr_addr;
            buf_data[wr_ptr_q] <= wr_data;
        end
    end

`ifdef IMEM_ARB_STATS_EN
    logic [15:0] stat_q, stat_d;

    // Saturating count of refused fetch cycles
    always_comb begin
        stat_d = stat_q;
        if (fetch_req && !gnt && (stat_q != 16'hFFFF)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    // Statistics register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_fetch_stalls = stat_q;
`endif

    assign fetch_gnt          = gnt && rst_n;
    assign wr_ready           = !full && rst_n;
    assign busy               = !empty || (state_q != ST_IDLE);
    assign fetch_valid        = fetch_valid_q;
    assign fetch_data         = fetch_data_q;
    assign mem_address_out    = mem_address_out_q;
    assign mem_address_in     = mem_address_in_q;
    assign mem_instruction_in = mem_instruction_in_q;
    assign mem_write          = mem_write_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a falling-edge memory model.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [15:0] fetch_data;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        busy;
    logic [15:0] mem_address_out;
    logic [15:0] mem_address_in;
    logic [15:0] mem_instruction_in;
    logic        mem_write;
    logic [15:0] mem_instruction_out = '0;
`ifdef IMEM_ARB_STATS_EN
    logic [15:0] stat_fetch_stalls;
`endif

    int total = 0;
    int bad = 0;

    logic [15:0] mem [0:255];
    logic        mem_init_done = 1'b0;

    imem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .WBUF_DEPTH(4), .MAX_STALL(8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_req          (fetch_req),
        .fetch_addr         (fetch_addr),
        .fetch_gnt          (fetch_gnt),
        .fetch_valid        (fetch_valid),
        .fetch_data         (fetch_data),
        .wr_valid           (wr_valid),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .wr_ready           (wr_ready),
        .busy               (busy),
        .mem_address_out    (mem_address_out),
        .mem_address_in     (mem_address_in),
        .mem_instruction_in (mem_instruction_in),
        .mem_write          (mem_write),
`ifdef IMEM_ARB_STATS_EN
        .stat_fetch_stalls  (stat_fetch_stalls),
`endif
        .mem_instruction_out(mem_instruction_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 16'hA5A5;
        return {a, ~a};
    endfunction

    // Memory: samples command on the falling edge; read inhibited while writing
    always @(negedge clk) begin
        if (!mem_init_done) begin
            for (int a = 0; a < 256; a++) mem[a] = init_val(8'(a));
            mem_init_done = 1'b1;
        end
        if (mem_write) mem[mem_address_in[7:0]] = mem_instruction_in;
        else mem_instruction_out = mem[mem_address_out[7:0]];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_req = 1'b0;
        wr_valid = 1'b0;
        fetch_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_req = 1'b1;
        fetch_addr = 16'h0010;
        wr_valid = 1'b1;
        wr_addr = 16'h0020;
        #2;
        total++; if (fetch_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%0b want=0", fetch_gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
        cyc();
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", fetch_valid); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rst_mem_write got=%0b want=0", mem_write); end
        total++; if (mem_address_out !== 16'h0) begin bad++; $display("FAIL rst_addr_out got=%h want=0000", mem_address_out); end
`ifdef IMEM_ARB_STATS_EN
        total++; if (stat_fetch_stalls !== 16'h0) begin bad++; $display("FAIL rst_stat got=%0d want=0", stat_fetch_stalls); end
`endif
        do_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_after got=%0b want=0", busy); end
    endtask

    task automatic test_fetch();
        do_reset();
        fetch_req = 1'b1;
        fetch_addr = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++; if (fetch_gnt !== 1'b1) begin bad++; $display("FAIL fetch_gnt_%0d got=%0b want=1", i, fetch_gnt); end
            cyc();
            total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL fetch_mem_write_%0d got=%0b want=0", i, mem_write); end
            total++; if (fetch_valid !== (i > 0)) begin bad++; $display("FAIL fetch_valid_%0d got=%0b want=%0b", i, fetch_valid, (i > 0)); end
            if (i > 0) begin
                total++; if (fetch_data !== 16'hA5A5) begin bad++; $display("FAIL fetch_data_%0d got=%h want=a5a5", i, fetch_data); end
            end
        end
        fetch_req = 1'b0;
        cyc();
        total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL fetch_last_valid got=%0b want=1", fetch_valid); end
        cyc();
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL fetch_valid_drop got=%0b want=0", fetch_valid); end
        total++; if (fetch_data !== 16'hA5A5) begin bad++; $display("FAIL fetch_data_hold got=%h want=a5a5", fetch_data); end
    endtask

    task automatic test_write_burst();
        logic [15:0] exp_d;
        do_reset();
        // Fetches keep the port so the buffer can fill up
        fetch_req = 1'b1;
        fetch_addr = 16'h0050;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr = 16'(32'h20 + i);
            wr_data = 16'(i + 1) * 16'h1111;
            #2;
            total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL wb_ready_%0d got=%0b want=1", i, wr_ready); end
            cyc();
        end
        // Push attempt while full must be dropped
        wr_addr = 16'h0024;
        wr_data = 16'h5555;
        #2;
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL wb_ready_full got=%0b want=0", wr_ready); end
        total++; if (fetch_gnt !== 1'b0) begin bad++; $display("FAIL wb_gnt_full got=%0b want=0", fetch_gnt); end
        cyc();
        wr_valid = 1'b0;
        fetch_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            exp_d = 16'(i + 1) * 16'h1111;
            total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL wb_write_%0d got=%0b want=1", i, mem_write); end
            total++; if (mem_address_in !== 16'(32'h20 + i)) begin bad++; $display("FAIL wb_addr_%0d got=%h want=%h", i, mem_address_in, 16'(32'h20 + i)); end
            total++; if (mem_instruction_in !== exp_d) begin bad++; $display("FAIL wb_data_%0d got=%h want=%h", i, mem_instruction_in, exp_d); end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wb_busy_last got=%0b want=1", busy); end
        cyc();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wb_busy_done got=%0b want=0", busy); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL wb_write_done got=%0b want=0", mem_write); end
        for (int i = 0; i < 4; i++) begin
            exp_d = 16'(i + 1) * 16'h1111;
            total++; if (mem[8'(32'h20 + i)] !== exp_d) begin bad++; $display("FAIL wb_mem_%0d got=%h want=%h", i, mem[8'(32'h20 + i)], exp_d); end
        end
        total++; if (mem[8'h24] !== init_val(8'h24)) begin bad++; $display("FAIL wb_mem_dropped got=%h want=%h", mem[8'h24], init_val(8'h24)); end
    endtask

    task automatic test_hazard();
        do_reset();
        fetch_req = 1'b1;
        fetch_addr = 16'h0040;
        wr_valid = 1'b1;
        wr_addr = 16'h0030;
        wr_data = 16'hBEEF;
        #2;
        total++; if (fetch_gnt !== 1'b1) begin bad++; $display("FAIL hz_gnt_first got=%0b want=1", fetch_gnt); end
        cyc();
        wr_valid = 1'b0;
        fetch_addr = 16'h0030;
        #2;
        total++; if (fetch_gnt !== 1'b0) begin bad++; $display("FAIL hz_gnt_blocked got=%0b want=0", fetch_gnt); end
        cyc();
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL hz_write got=%0b want=1", mem_write); end
        total++; if (mem_address_in !== 16'h0030) begin bad++; $display("FAIL hz_write_addr got=%h want=0030", mem_address_in); end
        total++; if (fetch_data !== init_val(8'h40)) begin bad++; $display("FAIL hz_data_other got=%h want=%h", fetch_data, init_val(8'h40)); end
        #2;
        total++; if (fetch_gnt !== 1'b1) begin bad++; $display("FAIL hz_gnt_after got=%0b want=1", fetch_gnt); end
        cyc();
        fetch_req = 1'b0;
        total++; if (mem_address_out !== 16'h0030) begin bad++; $display("FAIL hz_read_addr got=%h want=0030", mem_address_out); end
        cyc();
        total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL hz_valid got=%0b want=1", fetch_valid); end
        total++; if (fetch_data !== 16'hBEEF) begin bad++; $display("FAIL hz_data got=%h want=beef", fetch_data); end
`ifdef IMEM_ARB_STATS_EN
        total++; if (stat_fetch_stalls !== 16'd1) begin bad++; $display("FAIL hz_stat got=%0d want=1", stat_fetch_stalls); end
`endif
    endtask

    task automatic test_forced_drain();
        do_reset();
        fetch_req = 1'b1;
        fetch_addr = 16'h0060;
        wr_valid = 1'b1;
        wr_addr = 16'h0070;
        wr_data = 16'h7777;
        cyc();
        wr_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #2;
            total++; if (fetch_gnt !== 1'b1) begin bad++; $display("FAIL fd_gnt_%0d got=%0b want=1", k, fetch_gnt); end
            cyc();
            total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL fd_early_write_%0d got=%0b want=0", k, mem_write); end
        end
        total++; if (fetch_data !== init_val(8'h60)) begin bad++; $display("FAIL fd_data got=%h want=%h", fetch_data, init_val(8'h60)); end
        #2;
        total++; if (fetch_gnt !== 1'b0) begin bad++; $display("FAIL fd_gnt_forced got=%0b want=0", fetch_gnt); end
        cyc();
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL fd_write got=%0b want=1", mem_write); end
        total++; if (mem_address_in !== 16'h0070) begin bad++; $display("FAIL fd_write_addr got=%h want=0070", mem_address_in); end
        for (int k = 0; k < 10; k++) begin
            #2;
            total++; if (fetch_gnt !== 1'b1) begin bad++; $display("FAIL fd_gnt_post_%0d got=%0b want=1", k, fetch_gnt); end
            cyc();
            total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL fd_extra_write_%0d got=%0b want=0", k, mem_write); end
        end
        fetch_req = 1'b0;
        cyc();
        total++; if (mem[8'h70] !== 16'h7777) begin bad++; $display("FAIL fd_mem got=%h want=7777", mem[8'h70]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fetch_req = 1'b1;
        fetch_addr = 16'h0090;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr = 16'(32'h80 + i);
            wr_data = 16'hC000 + 16'(i);
            cyc();
        end
        wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0b want=0", fetch_valid); end
        total++; if (mem_address_out !== 16'h0) begin bad++; $display("FAIL rm_addr_out got=%h want=0000", mem_address_out); end
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rm_mem_write got=%0b want=0", mem_write); end
        total++; if (fetch_gnt !== 1'b0) begin bad++; $display("FAIL rm_gnt got=%0b want=0", fetch_gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%0b want=0", busy); end
        fetch_req = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rm_valid_after_%0d got=%0b want=0", k, fetch_valid); end
            total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rm_write_after_%0d got=%0b want=0", k, mem_write); end
        end
        for (int i = 0; i < 3; i++) begin
            total++; if (mem[8'(32'h80 + i)] !== init_val(8'(32'h80 + i))) begin
                bad++; $display("FAIL rm_mem_%0d got=%h want=%h", i, mem[8'(32'h80 + i)], init_val(8'(32'h80 + i)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_burst();
        test_hazard();
        test_forced_drain();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
